stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500_000, giving the stable-input cycles required before a debounced level changes.
REQ-002 The block SHALL have parameter BLINK_DIV, default 25_000_000, giving the i_clk cycles between o_blink toggles.
REQ-003 i_clk  input  1  single system clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_btn_pause  input  1  raw pause/resume pushbutton, asynchronous, active-high.
REQ-006 i_btn_rst  input  1  raw clear pushbutton, asynchronous, active-high.
REQ-007 i_sw_adj  input  1  raw adjust-mode switch, asynchronous.
REQ-008 i_sw_sel  input  1  raw adjust-select switch, asynchronous: 1 = minutes, 0 = seconds.
REQ-009 o_cnt_en  output  1  count enable to the minute/second counter.
REQ-010 o_cnt_clr  output  1  one-cycle synchronous clear pulse to the counter.
REQ-011 o_adj  output  1  adjust-mode indication to the counter.
REQ-012 o_sel  output  1  adjust field select to the counter.
REQ-013 o_paused  output  1  high while the controller is paused.
REQ-014 o_blink  output  1  display blink phase for the field being adjusted.
REQ-015 o_state  output  2  current FSM state encoding.

Function
REQ-016 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-017 Each synchronized input SHALL have its own debouncer: the debounced level SHALL take the synchronized value once it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL zero that debouncer's counter.
REQ-018 A press event SHALL be a single-cycle pulse in the cycle after a button's debounced level goes 0->1; releases SHALL generate no event.
REQ-019 FSM states SHALL be RUN=2'b00, PAUSE=2'b01, ADJUST=2'b10, CLEAR=2'b11, and o_state SHALL equal the current state.
REQ-020 RUN: rst press -> CLEAR; otherwise debounced adj=1 -> ADJUST; otherwise pause press -> PAUSE; otherwise stay.
REQ-021 PAUSE: rst press -> CLEAR; otherwise debounced adj=1 -> ADJUST; otherwise pause press -> RUN; otherwise stay.
REQ-022 ADJUST: rst press -> CLEAR; otherwise debounced adj=0 -> PAUSE; pause presses SHALL be ignored.
REQ-023 CLEAR SHALL last exactly one cycle and then go to PAUSE unconditionally; presses arriving during CLEAR SHALL be discarded.
REQ-024 When events coincide, priority SHALL be rst press > adj level > pause press.
REQ-025 Outputs SHALL be registered and SHALL reflect the current state, with no combinational path from any input.
REQ-026 Output mapping: o_cnt_en=1 in RUN and ADJUST; o_adj=1 only in ADJUST; o_sel = debounced sel in ADJUST, else 0; o_cnt_clr=1 only in CLEAR; o_paused=1 only in PAUSE.
REQ-027 A change of debounced sel while in ADJUST SHALL update o_sel one cycle later without a state change.

Reset
REQ-028 While i_rst_n=0, the following SHALL hold: state = PAUSE; all synchronizer flops, debounced levels and debounce counters = 0; blink counter = 0; o_cnt_en=0, o_cnt_clr=0, o_adj=0, o_sel=0, o_paused=1, o_blink=0, o_state=2'b01.
REQ-029 Reset asserted mid-operation (any state, any debounce count) SHALL take effect immediately; after release the FSM SHALL leave PAUSE only on fresh debounced events.
REQ-030 A switch held at 1 through reset SHALL cause entry to ADJUST once it has been synchronized and debounced after release.

Configuration
REQ-031 With macro STOPWATCH_BLINK_EN defined, a counter SHALL run only in ADJUST and toggle o_blink every BLINK_DIV cycles, starting at o_blink=0 on ADJUST entry.
REQ-032 With STOPWATCH_BLINK_EN defined, leaving ADJUST SHALL clear the blink counter and o_blink in the next cycle.
REQ-033 Without STOPWATCH_BLINK_EN, o_blink SHALL be constant 0 and the blink counter logic SHALL not be instantiated.

Verification (DEBOUNCE_CYCLES=4, BLINK_DIV=8)
REQ-034 Reset release, no stimulus -> o_state=01, o_paused=1, all other outputs 0 for 100 cycles.
REQ-035 Pause button held high 3 cycles, then low -> no state change; held high 10 cycles -> RUN with o_cnt_en=1; a second press -> PAUSE.
REQ-036 In RUN, rst and pause pressed in the same cycle -> CLEAR for exactly 1 cycle with o_cnt_clr=1, then PAUSE.
REQ-037 i_sw_adj=1 and i_sw_sel=1 held -> ADJUST with o_adj=1, o_sel=1, o_cnt_en=1; sel dropped to 0 -> o_sel=0; pause press -> no change; adj dropped to 0 -> PAUSE.
REQ-038 With STOPWATCH_BLINK_EN, 40 cycles in ADJUST -> o_blink toggles every 8 cycles; leaving ADJUST -> o_blink=0 next cycle. Without the macro -> o_blink stays 0.
REQ-039 i_rst_n pulsed low mid-debounce while in RUN -> outputs reach reset values without waiting for a clock edge, and the partial press produces no event.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller port bundle: raw pushbutton/switch inputs and the
// registered control outputs that drive the minute/second counter.
// The master side (board / bench) drives the raw inputs; the slave side
// (stopwatch_ctrl) consumes them and drives the control outputs.
interface stopwatch_ctrl_if;
    logic       i_btn_pause;
    logic       i_btn_rst;
    logic       i_sw_adj;
    logic       i_sw_sel;
    logic       o_cnt_en;
    logic       o_cnt_clr;
    logic       o_adj;
    logic       o_sel;
    logic       o_paused;
    logic       o_blink;
    logic [1:0] o_state;

    modport master (
        output i_btn_pause, i_btn_rst, i_sw_adj, i_sw_sel,
        input  o_cnt_en, o_cnt_clr, o_adj, o_sel, o_paused, o_blink, o_state
    );

    modport slave (
        input  i_btn_pause, i_btn_rst, i_sw_adj, i_sw_sel,
        output o_cnt_en, o_cnt_clr, o_adj, o_sel, o_paused, o_blink, o_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronizes and debounces two pushbuttons and two
// switches, runs a RUN/PAUSE/ADJUST/CLEAR state machine and drives
// registered control outputs for the minute/second counter.
// Optional feature: define STOPWATCH_BLINK_EN to build the adjust-mode blink
// divider; without it o_blink is tied low and no blink counter exists.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BLINK_DIV       = 25_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    stopwatch_ctrl_if.slave ifc
);

    // Input lane indices shared by the synchronizer and debouncer arrays.
    localparam int N_IN      = 4;
    localparam int IDX_PAUSE = 0;
    localparam int IDX_RST   = 1;
    localparam int IDX_ADJ   = 2;
    localparam int IDX_SEL   = 3;

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int                DEB_CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_CW-1:0] DEB_LAST = DEB_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_CW-1:0] DEB_ONE  = DEB_CW'(1);
    localparam logic [DEB_CW-1:0] DEB_ZERO = DEB_CW'(0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSE  = 2'b01,
        ST_ADJUST = 2'b10,
        ST_CLEAR  = 2'b11
    } state_t;

    logic [N_IN-1:0]   raw_s;
    logic [N_IN-1:0]   sync1_r;
    logic [N_IN-1:0]   sync2_r;
    logic [N_IN-1:0]   db_r;
    logic [DEB_CW-1:0] deb_cnt_r [N_IN];
    logic [1:0]        btn_prev_r;
    logic              press_pause_s;
    logic              press_rst_s;
    logic              adj_lvl_s;
    logic              sel_lvl_s;

    state_t            state_r;
    state_t            next_state_s;

    logic              cnt_en_s;
    logic              cnt_clr_s;
    logic              adj_s;
    logic              sel_s;
    logic              paused_s;
    logic              cnt_en_r;
    logic              cnt_clr_r;
    logic              adj_r;
    logic              sel_r;
    logic              paused_r;

    assign raw_s = {ifc.i_sw_sel, ifc.i_sw_adj, ifc.i_btn_rst, ifc.i_btn_pause};

    // Two-flop synchronizer on every raw asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_r <= {N_IN{1'b0}};
            sync2_r <= {N_IN{1'b0}};
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-lane debouncer: adopt the synchronized level after it has disagreed
    // with the debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            db_r <= {N_IN{1'b0}};
            for (int i = 0; i < N_IN; i++) begin
                deb_cnt_r[i] <= DEB_ZERO;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_r[i] != db_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        db_r[i]      <= sync2_r[i];
                        deb_cnt_r[i] <= DEB_ZERO;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
                    end
                end else begin
                    deb_cnt_r[i] <= DEB_ZERO;
                end
            end
        end
    end

    // Previous debounced button levels, for rising-edge (press) detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_prev_r <= 2'b00;
        end else begin
            btn_prev_r <= {db_r[IDX_RST], db_r[IDX_PAUSE]};
        end
    end

    // Presses are one-cycle pulses; releases produce nothing.
    assign press_pause_s = db_r[IDX_PAUSE] & ~btn_prev_r[0];
    assign press_rst_s   = db_r[IDX_RST]   & ~btn_prev_r[1];
    assign adj_lvl_s     = db_r[IDX_ADJ];
    assign sel_lvl_s     = db_r[IDX_SEL];

    // FSM state register; reset parks the controller in PAUSE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_PAUSE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic with priority rst press > adj level > pause press.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (press_rst_s) begin
                    next_state_s = ST_CLEAR;
                end else if (adj_lvl_s) begin
                    next_state_s = ST_ADJUST;
                end else if (press_pause_s) begin
                    next_state_s = ST_PAUSE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (press_rst_s) begin
                    next_state_s = ST_CLEAR;
                end else if (adj_lvl_s) begin
                    next_state_s = ST_ADJUST;
                end else if (press_pause_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_PAUSE;
                end
            end
            ST_ADJUST: begin
                // Pause presses are deliberately ignored while adjusting.
                if (press_rst_s) begin
                    next_state_s = ST_CLEAR;
                end else if (!adj_lvl_s) begin
                    next_state_s = ST_PAUSE;
                end else begin
                    next_state_s = ST_ADJUST;
                end
            end
            ST_CLEAR: begin
                // Single-cycle clear; any press landing here is dropped.
                next_state_s = ST_PAUSE;
            end
            default: begin
                next_state_s = ST_PAUSE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state register after the same clock edge.
    always_comb begin
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        adj_s     = 1'b0;
        sel_s     = 1'b0;
        paused_s  = 1'b0;
        case (next_state_s)
            ST_RUN: begin
                cnt_en_s = 1'b1;
            end
            ST_PAUSE: begin
                paused_s = 1'b1;
            end
            ST_ADJUST: begin
                cnt_en_s = 1'b1;
                adj_s    = 1'b1;
                sel_s    = sel_lvl_s;
            end
            ST_CLEAR: begin
                cnt_clr_s = 1'b1;
            end
            default: begin
                paused_s = 1'b1;
            end
        endcase
    end

    // Output register: no combinational path from any input to a port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_en_r  <= 1'b0;
            cnt_clr_r <= 1'b0;
            adj_r     <= 1'b0;
            sel_r     <= 1'b0;
            paused_r  <= 1'b1;
        end else begin
            cnt_en_r  <= cnt_en_s;
            cnt_clr_r <= cnt_clr_s;
            adj_r     <= adj_s;
            sel_r     <= sel_s;
            paused_r  <= paused_s;
        end
    end

    assign ifc.o_cnt_en  = cnt_en_r;
    assign ifc.o_cnt_clr = cnt_clr_r;
    assign ifc.o_adj     = adj_r;
    assign ifc.o_sel     = sel_r;
    assign ifc.o_paused  = paused_r;
    assign ifc.o_state   = state_r;

`ifdef STOPWATCH_BLINK_EN
    localparam int                BLK_CW   = $clog2(BLINK_DIV + 1);
    localparam logic [BLK_CW-1:0] BLK_LAST = BLK_CW'(BLINK_DIV - 1);
    localparam logic [BLK_CW-1:0] BLK_ONE  = BLK_CW'(1);
    localparam logic [BLK_CW-1:0] BLK_ZERO = BLK_CW'(0);

    logic [BLK_CW-1:0] blink_cnt_r;
    logic              blink_r;

    // Blink divider: runs only while adjusting, restarts low on each entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt_r <= BLK_ZERO;
            blink_r     <= 1'b0;
        end else if (state_r == ST_ADJUST) begin
            if (blink_cnt_r == BLK_LAST) begin
                blink_cnt_r <= BLK_ZERO;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLK_ONE;
            end
        end else begin
            blink_cnt_r <= BLK_ZERO;
            blink_r     <= 1'b0;
        end
    end

    assign ifc.o_blink = blink_r;
`else
    // Blink disabled: tied low (the divider term is constant for any legal
    // divider and only keeps the parameter referenced).
    assign ifc.o_blink = 1'b0 & (BLINK_DIV > 0);
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, BLINK_DIV=8.
// A cycle-level behavioural model predicts every output; a negedge compare
// process checks the DUT against it, and directed steps add literal checks.
module tb_stopwatch_ctrl;

    localparam int DC = 4;
    localparam int BD = 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic chk_en  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl_if ifc ();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .BLINK_DIV       (BD)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .ifc     (ifc)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    // Input lanes: 0 pause, 1 rst, 2 adj, 3 sel.
    logic [3:0] m_hist;      // raw value one edge ago
    logic [3:0] m_sync;      // raw value two edges ago (what debouncers see)
    logic [3:0] m_db;        // debounced levels
    logic [3:0] m_db_last;   // debounced levels one cycle earlier
    int         m_streak [4];
    int         m_state;     // 0 RUN, 1 PAUSE, 2 ADJUST, 3 CLEAR
    logic       m_sel;
    logic       m_blink;
    int         m_adj_run;   // consecutive cycles spent in ADJUST

    task automatic model_reset();
        m_hist    = 4'b0000;
        m_sync    = 4'b0000;
        m_db      = 4'b0000;
        m_db_last = 4'b0000;
        for (int i = 0; i < 4; i++) m_streak[i] = 0;
        m_state   = 1;
        m_sel     = 1'b0;
        m_blink   = 1'b0;
        m_adj_run = 0;
    endtask

    task automatic model_step();
        logic pp;
        logic pr;
        int   nxt;
        pp  = m_db[0] && !m_db_last[0];
        pr  = m_db[1] && !m_db_last[1];
        nxt = m_state;
        if (m_state == 3)      nxt = 1;
        else if (pr)           nxt = 3;
        else if (m_state == 2) nxt = m_db[2] ? 2 : 1;
        else if (m_db[2])      nxt = 2;
        else if (pp)           nxt = (m_state == 0) ? 1 : 0;
        // blink phase = parity of completed BD-cycle periods inside ADJUST
        if (m_state == 2) begin
            m_adj_run = m_adj_run + 1;
`ifdef STOPWATCH_BLINK_EN
            m_blink = ((m_adj_run / BD) % 2) == 1;
`else
            m_blink = 1'b0;
`endif
        end else begin
            m_adj_run = 0;
            m_blink   = 1'b0;
        end
        m_sel     = (nxt == 2) ? m_db[3] : 1'b0;
        m_db_last = m_db;
        for (int i = 0; i < 4; i++) begin
            if (m_sync[i] != m_db[i]) begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] == DC) begin
                    m_db[i]     = m_sync[i];
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_sync  = m_hist;
        m_hist  = {ifc.i_sw_sel, ifc.i_sw_adj, ifc.i_btn_rst, ifc.i_btn_pause};
        m_state = nxt;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) model_reset();
            else          model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("m_state",   ifc.o_state,   2'(m_state));
            check("m_cnt_en",  ifc.o_cnt_en,  2'(m_state == 0 || m_state == 2));
            check("m_cnt_clr", ifc.o_cnt_clr, 2'(m_state == 3));
            check("m_adj",     ifc.o_adj,     2'(m_state == 2));
            check("m_paused",  ifc.o_paused,  2'(m_state == 1));
            check("m_sel",     ifc.o_sel,     2'(m_sel));
            check("m_blink",   ifc.o_blink,   2'(m_blink));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic press_pause(input int hold);
        ifc.i_btn_pause = 1'b1;
        idle(hold);
        ifc.i_btn_pause = 1'b0;
        idle(12);
    endtask

    // Bounded wait for a state; an expired bound shows up as a failed check.
    task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
        int k;
        k = 0;
        while (ifc.o_state !== s && k < lim) begin
            @(negedge i_clk);
            k = k + 1;
        end
        check(nm, ifc.o_state, s);
    endtask

    initial begin
        ifc.i_btn_pause = 1'b0;
        ifc.i_btn_rst   = 1'b0;
        ifc.i_sw_adj    = 1'b0;
        ifc.i_sw_sel    = 1'b0;
        i_rst_n         = 1'b0;
        idle(3);
        chk_en = 1'b1;
        check("rst_state",  ifc.o_state,  2'b01);
        check("rst_paused", ifc.o_paused, 2'b01);
        check("rst_cnt_en", ifc.o_cnt_en, 2'b00);
        check("rst_blink",  ifc.o_blink,  2'b00);
        i_rst_n = 1'b1;

        // Idle after release: stays paused.
        idle(100);
        check("idle_state", ifc.o_state, 2'b01);

        // Short glitch is filtered, long press toggles PAUSE<->RUN.
        press_pause(3);
        check("glitch_state", ifc.o_state, 2'b01);
        press_pause(10);
        check("run_state",  ifc.o_state,  2'b00);
        check("run_cnt_en", ifc.o_cnt_en, 2'b01);
        press_pause(10);
        check("pause_state", ifc.o_state, 2'b01);
        press_pause(10);
        check("run2_state", ifc.o_state, 2'b00);

        // Simultaneous rst and pause in RUN: one-cycle CLEAR, then PAUSE.
        ifc.i_btn_rst   = 1'b1;
        ifc.i_btn_pause = 1'b1;
        wait_state(2'b11, 15, "clear_entry");
        check("clear_pulse", ifc.o_cnt_clr, 2'b01);
        @(negedge i_clk);
        check("clear_exit",  ifc.o_state,   2'b01);
        check("clear_done",  ifc.o_cnt_clr, 2'b00);
        ifc.i_btn_rst   = 1'b0;
        ifc.i_btn_pause = 1'b0;
        idle(12);
        check("clear_settle", ifc.o_state, 2'b01);

        // ADJUST with minutes selected.
        ifc.i_sw_adj = 1'b1;
        ifc.i_sw_sel = 1'b1;
        wait_state(2'b10, 15, "adj_entry");
        check("adj_adj",    ifc.o_adj,    2'b01);
        check("adj_sel",    ifc.o_sel,    2'b01);
        check("adj_cnt_en", ifc.o_cnt_en, 2'b01);
        check("adj_blink0", ifc.o_blink,  2'b00);
`ifdef STOPWATCH_BLINK_EN
        idle(7);
        check("blink_pre",  ifc.o_blink, 2'b00);
        idle(1);
        check("blink_tog1", ifc.o_blink, 2'b01);
        idle(8);
        check("blink_tog2", ifc.o_blink, 2'b00);
        idle(24);
`else
        idle(40);
        check("blink_off", ifc.o_blink, 2'b00);
`endif
        ifc.i_sw_sel = 1'b0;
        idle(10);
        check("sel_drop",  ifc.o_sel,   2'b00);
        check("sel_state", ifc.o_state, 2'b10);
        press_pause(10);
        check("adj_ign_pause", ifc.o_state, 2'b10);
        ifc.i_sw_adj = 1'b0;
        wait_state(2'b01, 15, "adj_exit");
        check("adj_exit_adj", ifc.o_adj, 2'b00);
        @(negedge i_clk);
        check("adj_exit_blink", ifc.o_blink, 2'b00);

        // Asynchronous reset mid-debounce while running.
        press_pause(10);
        check("run3_state", ifc.o_state, 2'b00);
        ifc.i_btn_pause = 1'b1;
        idle(3);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_state",  ifc.o_state,  2'b01);
        check("async_paused", ifc.o_paused, 2'b01);
        check("async_cnt_en", ifc.o_cnt_en, 2'b00);
        ifc.i_btn_pause = 1'b0;
        idle(2);
        i_rst_n = 1'b1;
        idle(20);
        check("async_after", ifc.o_state, 2'b01);

        // Adjust switch held through reset enters ADJUST after release.
        ifc.i_sw_adj = 1'b1;
        idle(2);
        i_rst_n = 1'b0;
        idle(3);
        check("held_in_rst", ifc.o_state, 2'b01);
        i_rst_n = 1'b1;
        wait_state(2'b10, 15, "held_adj_entry");
        ifc.i_sw_adj = 1'b0;
        wait_state(2'b01, 15, "held_adj_exit");
        idle(5);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
